// File: rtl/muldiv_pkg.sv
// Shared types and constants for the EX-stage multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL_WAIT,
        ST_DIV_WAIT,
        ST_DONE
    } state_t;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;
    localparam int          CNT_W   = 4;

    function automatic logic is_div_op(input logic [1:0] kind);
        return (kind == OP_DIV) || (kind == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [1:0] kind);
        return (kind == OP_MULT) || (kind == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_sched.sv
// Sequences one mult/multu/div/divu at a time: starts the unit, stalls EX until
// the 64-bit result is captured, then presents the HI/LO write until EX advances.
module muldiv_sched
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [1:0]  op_kind,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        ex_adv,
    input  logic        flush,
    output logic        stallreq,
    output logic        mul_start,
    output logic        mul_signed,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_opdata1,
    output logic [31:0] div_opdata2,
    output logic        div_annul,
    input  logic [63:0] div_result,
    input  logic        div_ready,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata
);

    localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LAT - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [31:0]        div_a_q, div_a_d, div_b_q, div_b_d;
    logic               mul_signed_q, mul_signed_d;
    logic               div_signed_q, div_signed_d;
    logic [63:0]        res_q, res_d;

    // NOTE: every register here is reset, including operands and the result,
    // because they drive outputs directly and must read 0 during reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            div_a_q      <= '0;
            div_b_q      <= '0;
            mul_signed_q <= 1'b0;
            div_signed_q <= 1'b0;
            res_q        <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            div_a_q      <= div_a_d;
            div_b_q      <= div_b_d;
            mul_signed_q <= mul_signed_d;
            div_signed_q <= div_signed_d;
            res_q        <= res_d;
        end
    end

    always_comb begin
        // NOTE: hold-value defaults first so no path leaves a signal unassigned (no latch).
        state_d      = state_q;
        cnt_d        = cnt_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        div_a_d      = div_a_q;
        div_b_d      = div_b_q;
        mul_signed_d = mul_signed_q;
        div_signed_d = div_signed_q;
        res_d        = res_q;

        unique case (state_q)
            ST_IDLE: begin
                if (op_valid && !flush) begin
                    if (is_div_op(op_kind)) begin
                        div_a_d      = src_a;
                        div_b_d      = src_b;
                        div_signed_d = is_signed_op(op_kind);
                        if (src_b == 32'd0) begin
                            res_d   = {src_a, DIV0_LO};
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_DIV_WAIT;
                        end
                    end else begin
                        mul_a_d      = src_a;
                        mul_b_d      = src_b;
                        mul_signed_d = is_signed_op(op_kind);
                        cnt_d        = MUL_CNT_INIT;
                        state_d      = ST_MUL_WAIT;
                    end
                end
            end
            ST_MUL_WAIT: begin
                if (cnt_q == '0) begin
                    res_d   = mul_result;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DIV_WAIT: begin
                if (div_ready) begin
                    res_d   = div_result;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (ex_adv) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Flush wins over a same-cycle completion: nothing is captured.
        if (flush) begin
            state_d = ST_IDLE;
            res_d   = res_q;
        end
    end

    assign stallreq = !rst && (((state_q == ST_IDLE) && op_valid && !flush)
                               || (state_q == ST_MUL_WAIT)
                               || (state_q == ST_DIV_WAIT));

    assign mul_start   = (state_q == ST_MUL_WAIT) && (cnt_q == MUL_CNT_INIT);
    assign mul_signed  = mul_signed_q;
    assign mul_ina     = mul_a_q;
    assign mul_inb     = mul_b_q;

    assign div_start   = (state_q == ST_DIV_WAIT) && !flush;
    assign div_annul   = (state_q == ST_DIV_WAIT) && flush;
    assign div_signed  = div_signed_q;
    assign div_opdata1 = div_a_q;
    assign div_opdata2 = div_b_q;

    assign hi_we       = (state_q == ST_DONE) && !flush;
    assign lo_we       = hi_we;
    assign hi_wdata    = res_q[63:32];
    assign lo_wdata    = res_q[31:0];

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched with simple multiplier and divider unit models.
module tb_muldiv_sched;
    import muldiv_pkg::*;

    localparam int MUL_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid, ex_adv, flush;
    logic [1:0]  op_kind;
    logic [31:0] src_a, src_b;
    logic        stallreq, mul_start, mul_signed, div_start, div_signed, div_annul;
    logic [31:0] mul_ina, mul_inb, div_opdata1, div_opdata2;
    logic [63:0] mul_result, div_result;
    logic        div_ready;
    logic        hi_we, lo_we;
    logic [31:0] hi_wdata, lo_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_sched #(.MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_kind(op_kind),
        .src_a(src_a), .src_b(src_b), .ex_adv(ex_adv), .flush(flush),
        .stallreq(stallreq), .mul_start(mul_start), .mul_signed(mul_signed),
        .mul_ina(mul_ina), .mul_inb(mul_inb), .mul_result(mul_result),
        .div_start(div_start), .div_signed(div_signed),
        .div_opdata1(div_opdata1), .div_opdata2(div_opdata2),
        .div_annul(div_annul), .div_result(div_result), .div_ready(div_ready),
        .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
    );

    logic [199:0] all_outs;
    assign all_outs = {stallreq, mul_start, mul_signed, div_start, div_signed, div_annul,
                       hi_we, lo_we, mul_ina, mul_inb, div_opdata1, div_opdata2,
                       hi_wdata, lo_wdata};

    // Multiplier model: product is only valid MUL_LAT-1 cycles after the start pulse.
    logic [63:0] m_prod, m_prod_q;
    int          m_cnt;
    assign m_prod = mul_signed ? ({{32{mul_ina[31]}}, mul_ina} * {{32{mul_inb[31]}}, mul_inb})
                               : ({32'd0, mul_ina} * {32'd0, mul_inb});
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt    <= 0;
            m_prod_q <= '0;
        end else if (mul_start) begin
            m_cnt    <= 1;
            m_prod_q <= m_prod;
        end else if (m_cnt != 0 && m_cnt < 15) begin
            m_cnt <= m_cnt + 1;
        end
    end
    assign mul_result = (m_cnt == MUL_LAT - 1) ? m_prod_q : 64'hDEAD_BEEF_DEAD_BEEF;

    // Divider model: ready in the 33rd consecutive cycle of div_start.
    int          d_cnt;
    logic [31:0] d_q, d_r;
    always @(posedge clk or posedge rst) begin
        if (rst)                        d_cnt <= 0;
        else if (!div_start || div_annul) d_cnt <= 0;
        else                            d_cnt <= d_cnt + 1;
    end
    always_comb begin
        d_q = '0;
        d_r = '0;
        if (div_opdata2 != 0) begin
            if (div_signed) begin
                d_q = $signed(div_opdata1) / $signed(div_opdata2);
                d_r = $signed(div_opdata1) % $signed(div_opdata2);
            end else begin
                d_q = div_opdata1 / div_opdata2;
                d_r = div_opdata1 % div_opdata2;
            end
        end
    end
    assign div_ready  = div_start && (d_cnt == 32);
    assign div_result = div_ready ? {d_r, d_q} : 64'd0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] kind, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1;
        op_kind  = kind;
        src_a    = a;
        src_b    = b;
    endtask

    // Runs cycles until hi_we is seen at a negedge; returns there so the caller can inspect DONE.
    task automatic run_to_done(input int max_cycles, output int n_stall, output int n_mstart,
                               output int n_dstart, output int n_annul,
                               output logic [31:0] cap_a, output logic [31:0] cap_b,
                               output logic done);
        n_stall = 0; n_mstart = 0; n_dstart = 0; n_annul = 0;
        cap_a = '0; cap_b = '0; done = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (hi_we) begin
                done = 1'b1;
                break;
            end
            if (stallreq)  n_stall++;
            if (div_start) n_dstart++;
            if (div_annul) n_annul++;
            if (mul_start) begin
                n_mstart++;
                cap_a = mul_ina;
                cap_b = mul_inb;
            end
            step();
        end
    endtask

    task automatic retire();
        ex_adv = 1'b1;
        step();
        ex_adv   = 1'b0;
        op_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        op_valid = 1'b0; op_kind = '0; src_a = '0; src_b = '0; ex_adv = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (all_outs !== '0) begin
            errors++; $display("FAIL reset_outs got %h exp 0", all_outs);
        end
        rst = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if (stallreq !== 1'b0 || hi_we !== 1'b0) begin
            errors++; $display("FAIL reset_idle stallreq=%b hi_we=%b exp 0 0", stallreq, hi_we);
        end
        step();
    endtask

    task automatic test_multu();
        int ns, nm, nd, na;
        logic [31:0] ca, cb;
        logic done;
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        run_to_done(10, ns, nm, nd, na, ca, cb, done);
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL multu_timeout done=%b exp 1", done); end
        checks++;
        if (ns != 3) begin errors++; $display("FAIL multu_stall got %0d exp 3", ns); end
        checks++;
        if (nm != 1) begin errors++; $display("FAIL multu_start got %0d exp 1", nm); end
        checks++;
        if (ca !== 32'hFFFF_FFFF || cb !== 32'd2) begin
            errors++; $display("FAIL multu_operands got %h %h exp ffffffff 00000002", ca, cb);
        end
        checks++;
        if (hi_wdata !== 32'd1 || lo_wdata !== 32'hFFFF_FFFE || lo_we !== 1'b1 || stallreq !== 1'b0 || mul_signed !== 1'b0) begin
            errors++; $display("FAIL multu_result got hi=%h lo=%h lo_we=%b stall=%b sgn=%b exp 00000001 fffffffe 1 0 0",
                               hi_wdata, lo_wdata, lo_we, stallreq, mul_signed);
        end
        retire();
        @(negedge clk);
        checks++;
        if (hi_we !== 1'b0 || stallreq !== 1'b0) begin
            errors++; $display("FAIL multu_retire hi_we=%b stall=%b exp 0 0", hi_we, stallreq);
        end
        step();
    endtask

    task automatic test_div();
        int ns, nm, nd, na;
        logic [31:0] ca, cb;
        logic done;
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        run_to_done(60, ns, nm, nd, na, ca, cb, done);
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL div_timeout done=%b exp 1", done); end
        checks++;
        if (ns != 34 || nd != 33) begin
            errors++; $display("FAIL div_timing stall=%0d start=%0d exp 34 33", ns, nd);
        end
        checks++;
        if (hi_wdata !== 32'hFFFF_FFFF || lo_wdata !== 32'hFFFF_FFFD) begin
            errors++; $display("FAIL div_result got hi=%h lo=%h exp ffffffff fffffffd", hi_wdata, lo_wdata);
        end
        checks++;
        if (div_start !== 1'b0 || stallreq !== 1'b0 || div_signed !== 1'b1 || na != 0 || nm != 0) begin
            errors++; $display("FAIL div_done start=%b stall=%b sgn=%b annul=%0d mstart=%0d exp 0 0 1 0 0",
                               div_start, stallreq, div_signed, na, nm);
        end
        retire();
        step();
    endtask

    task automatic test_div_zero();
        int ns, nm, nd, na;
        logic [31:0] ca, cb;
        logic done;
        issue(OP_DIVU, 32'h0000_1234, 32'd0);
        run_to_done(10, ns, nm, nd, na, ca, cb, done);
        checks++;
        if (done !== 1'b1 || ns != 1 || nd != 0) begin
            errors++; $display("FAIL div0_timing done=%b stall=%0d start=%0d exp 1 1 0", done, ns, nd);
        end
        checks++;
        if (hi_wdata !== 32'h0000_1234 || lo_wdata !== 32'hFFFF_FFFF || div_start !== 1'b0) begin
            errors++; $display("FAIL div0_result got hi=%h lo=%h start=%b exp 00001234 ffffffff 0",
                               hi_wdata, lo_wdata, div_start);
        end
        retire();
        step();
    endtask

    task automatic test_flush_div();
        int annul_cnt = 0, we_cnt = 0, stall_after = 0, start_after = 0;
        issue(OP_DIVU, 32'd100, 32'd7);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (hi_we) we_cnt++;
            if (div_annul) annul_cnt++;
            step();
        end
        checks++;
        if (div_start !== 1'b1) begin errors++; $display("FAIL flush_pre div_start=%b exp 1", div_start); end
        flush = 1'b1;
        @(negedge clk);
        if (hi_we) we_cnt++;
        if (div_annul) annul_cnt++;
        step();
        flush = 1'b0;
        op_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (hi_we) we_cnt++;
            if (div_annul) annul_cnt++;
            if (stallreq) stall_after++;
            if (div_start) start_after++;
            step();
        end
        checks++;
        if (annul_cnt != 1) begin errors++; $display("FAIL flush_annul got %0d exp 1", annul_cnt); end
        checks++;
        if (we_cnt != 0 || stall_after != 0 || start_after != 0) begin
            errors++; $display("FAIL flush_idle we=%0d stall=%0d start=%0d exp 0 0 0", we_cnt, stall_after, start_after);
        end
    endtask

    task automatic test_flush_mul();
        int we_cnt = 0;
        issue(OP_MULT, 32'd9, 32'd9);
        step();
        step();
        flush = 1'b1;
        @(negedge clk);
        if (hi_we) we_cnt++;
        step();
        flush = 1'b0;
        op_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (hi_we || stallreq) we_cnt++;
            step();
        end
        checks++;
        if (we_cnt != 0) begin errors++; $display("FAIL flush_mul_last active=%0d exp 0", we_cnt); end
    endtask

    task automatic test_back_to_back();
        int ns, nm, nd, na;
        logic [31:0] ca, cb;
        logic done;
        logic [66:0] obs;
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
        run_to_done(10, ns, nm, nd, na, ca, cb, done);
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_timeout done=%b exp 1", done); end
        for (int k = 0; k < 5; k++) begin
            obs = {hi_we, lo_we, stallreq, hi_wdata, lo_wdata};
            checks++;
            if (obs !== {3'b110, 64'hFFFF_FFFF_FFFF_FFF1}) begin
                errors++; $display("FAIL b2b_hold cycle %0d got %h exp 6ffffffffffffff1", k, obs);
            end
            if (k == 4) begin
                ex_adv = 1'b1;
            end else begin
                step();
                @(negedge clk);
            end
        end
        step();
        ex_adv = 1'b0;
        issue(OP_MULTU, 32'd6, 32'd7);
        @(negedge clk);
        checks++;
        if (stallreq !== 1'b1 || mul_start !== 1'b0 || hi_we !== 1'b0) begin
            errors++; $display("FAIL b2b_idle stall=%b start=%b we=%b exp 1 0 0", stallreq, mul_start, hi_we);
        end
        step();
        run_to_done(10, ns, nm, nd, na, ca, cb, done);
        checks++;
        if (done !== 1'b1 || nm != 1 || ns != 2 || ca !== 32'd6 || cb !== 32'd7) begin
            errors++; $display("FAIL b2b_second done=%b start=%0d stall=%0d a=%h b=%h exp 1 1 2 00000006 00000007",
                               done, nm, ns, ca, cb);
        end
        checks++;
        if (hi_wdata !== 32'd0 || lo_wdata !== 32'd42) begin
            errors++; $display("FAIL b2b_result got hi=%h lo=%h exp 00000000 0000002a", hi_wdata, lo_wdata);
        end
        retire();
        step();
    endtask

    task automatic test_async_reset();
        int active = 0;
        issue(OP_MULT, 32'd3, 32'd4);
        step();
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (all_outs !== '0) begin errors++; $display("FAIL arst_outs got %h exp 0", all_outs); end
        op_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            @(negedge clk);
            if (stallreq || mul_start || hi_we) active++;
        end
        checks++;
        if (active != 0) begin errors++; $display("FAIL arst_idle active=%0d exp 0", active); end
        step();
    endtask

    initial begin
        test_reset();
        test_multu();
        test_div();
        test_div_zero();
        test_flush_div();
        test_flush_mul();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/muldiv_sched.md
# muldiv_sched

Sequencing controller for the EX-stage multiplier and divider. It accepts one mult/multu/div/divu operation at a time from EX and starts the correct unit with registered operands. It holds the pipeline with a stall request until the 64-bit result is captured, then presents the HI/LO write data to the EX→MEM bus until EX advances. It also handles flush (cancelling an in-flight divide) and a divide-by-zero shortcut.

## Interface
- MUL_LAT, 2, multiplier latency in cycles from operand presentation to valid `mul_result`; legal range 1..15.
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- op_valid  in  1  EX currently holds a mult/multu/div/divu.
- op_kind  in  2  operation code: 00 mult, 01 multu, 10 div, 11 divu.
- src_a  in  32  rs operand (dividend / multiplicand).
- src_b  in  32  rt operand (divisor / multiplier).
- ex_adv  in  1  EX register loads a new instruction at the next edge.
- flush  in  1  discard the current operation.
- stallreq  out  1  stall request toward the stall controller.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_signed  out  1  signed multiply.
- mul_ina, mul_inb  out  32  registered multiplier operands.
- mul_result  in  64  multiplier product.
- div_start  out  1  level start to the divider.
- div_signed  out  1  signed divide.
- div_opdata1, div_opdata2  out  32  registered divider operands.
- div_annul  out  1  one-cycle cancel pulse to the divider.
- div_result  in  64  {remainder, quotient}.
- div_ready  in  1  divider result valid.
- hi_we, lo_we  out  1  HI/LO write enables.
- hi_wdata, lo_wdata  out  32  HI/LO write data.

## Operation
- States:
  - IDLE: no operation in progress.
  - MUL_WAIT: multiplier running.
  - DIV_WAIT: divider running.
  - DONE: result captured, waiting for EX to advance.
- IDLE:
  - op_valid=1 and flush=0: latch src_a/src_b into the operand registers for the selected unit, and latch signed = ~op_kind[0].
  - Mult kinds go to MUL_WAIT with counter = MUL_LAT-1.
  - Div kinds with src_b≠0 go to DIV_WAIT.
  - Div kinds with src_b==0 go to DONE with HI=src_a, LO=32'hFFFF_FFFF; the divider is never started.
- MUL_WAIT:
  - mul_start=1 in the first cycle only.
  - Counter decrements each cycle.
  - When counter==0, capture mul_result into the result register and go to DONE.
- DIV_WAIT:
  - div_start=1 throughout.
  - On div_ready=1, capture div_result and go to DONE; div_start drops in DONE.
- DONE:
  - hi_we=lo_we=1, data from the result register; stallreq=0.
  - Stay while ex_adv=0; go to IDLE on ex_adv=1.
- stallreq = (IDLE & op_valid & ~flush) | MUL_WAIT | DIV_WAIT. It is combinational, so it is asserted in the same cycle the op first appears.
- flush=1 forces IDLE from any state:
  - No HI/LO write occurs.
  - div_annul=1 for one cycle if the state was DIV_WAIT.
  - Flush beats div_ready and counter==0 in the same cycle.
- Signed multiply and signed divide semantics are the units' responsibility; the controller only drives the signed flags.
- Reset: state IDLE, counter 0, operand and result registers 0, every output 0.

## Timing
- Multiply (MUL_LAT=2):
  - t0 IDLE with op_valid: stallreq=1.
  - t1 MUL_WAIT: mul_start=1.
  - t2 MUL_WAIT: result sampled.
  - t3 DONE: hi_we=1, stallreq=0.
  - Stall length = MUL_LAT+1 cycles.
- Divide:
  - Stall length = 1 + (cycles until div_ready).
  - DONE follows the cycle where div_ready=1.
- Divide by zero: exactly 1 stall cycle; DONE at t1.
- Back-to-back ops: DONE→IDLE on ex_adv. The next op in EX is treated as new in IDLE, which adds one idle cycle between ops and prevents reissuing the old one.
- DONE outputs hold steady for any number of ex_adv=0 cycles; the repeated write is idempotent.
- rst asserted mid-operation returns all outputs to 0 immediately (asynchronous). The external divider is reset by the same rst.

## Structure
- Shared package `muldiv_pkg`:
  - state enum.
  - op_kind codes.
  - DIV0_LO = 32'hFFFF_FFFF.
  - counter width (4).
- Single module. The mul and div units stay instantiated beside it in EX, and this block only drives and samples their ports. No sub-module is warranted.

## Test plan
- multu with src_a=32'hFFFF_FFFF, src_b=2, MUL_LAT=2 -> stallreq high for 3 cycles, mul_start one pulse, then hi_wdata=1, lo_wdata=32'hFFFF_FFFE, hi_we=lo_we=1.
- div with src_a=-7, src_b=2 and a divider model ready after 33 cycles -> div_start high until ready, then HI=32'hFFFF_FFFF (−1), LO=32'hFFFF_FFFD (−3), stallreq drops in DONE.
- divu with src_b=0, src_a=32'h1234 -> one stall cycle, div_start never 1, HI=32'h1234, LO=32'hFFFF_FFFF.
- flush during DIV_WAIT cycle 10 -> div_annul one pulse, IDLE next cycle, hi_we/lo_we never asserted, stallreq=0.
- DONE with ex_adv=0 for 4 cycles and then 1, with a second mult already in EX -> write outputs stable for all 5 cycles, one IDLE cycle, then a new mul_start using the new operands.
- rst pulse asserted asynchronously mid-MUL_WAIT -> all outputs 0 before the next edge; after release the state is IDLE.
